// File: rtl/mult_share_sched.sv
// Round-robin front end sharing one sequential shift-add multiplier among N
// requesters; results come back tagged with the owning requester index.
module mult_share_sched #(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int NQ = 8,
  parameter int TW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*M-1:0]    req_d,
  input  logic [N*NQ-1:0]   req_q,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [M+NQ-1:0]   res_prod,
  output logic [TW-1:0]     res_tag,
  output logic              busy
);

  localparam int CW = $clog2(NQ + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [M:0]      acc;
  logic [NQ-1:0]   qreg;
  logic [M-1:0]    d_reg;
  logic [TW-1:0]   tag;

  logic            found;
  logic [TW-1:0]   winner;
  logic [TW:0]     pos;
  logic [M:0]      sum;
  logic [M-1:0]    lane_d;
  logic [NQ-1:0]   lane_q;

  // Search from ptr upward, wrapping modulo N, for the first pending request.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (TW+1)'(i);
      if (pos >= (TW+1)'(N))
        pos = pos - (TW+1)'(N);
      if (!found && req_valid[pos[TW-1:0]]) begin
        found  = 1'b1;
        winner = pos[TW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready = N'(1) << winner;
  end

  assign lane_d = req_d[winner*M +: M];
  assign lane_q = req_q[winner*NQ +: NQ];

  // acc[M] is always zero between steps, so adding the full register equals
  // adding the low M bits with a cleared carry.
  assign sum = acc + (qreg[0] ? {1'b0, d_reg} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      acc       <= '0;
      qreg      <= '0;
      d_reg     <= '0;
      tag       <= '0;
      res_valid <= 1'b0;
      res_prod  <= '0;
      res_tag   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            d_reg <= lane_d;
            qreg  <= lane_q;
            acc   <= '0;
            tag   <= winner;
            cnt   <= CW'(NQ);
            ptr   <= (winner == TW'(N-1)) ? '0 : winner + TW'(1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= {1'b0, sum[M:1]};
          qreg <= {sum[0], qreg[NQ-1:1]};
          cnt  <= cnt - CW'(1);
          // The final shift lands directly in the output register.
          if (cnt == CW'(1)) begin
            res_prod  <= {sum, qreg[NQ-1:1]};
            res_tag   <= tag;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched: grants are predicted by a round-robin
// model, products by plain multiplication, and compared by a separate monitor.
module tb_mult_share_sched;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int NQ = 8;
  localparam int TW = 2;
  localparam int PW = M + NQ;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*M-1:0]    req_d = '0;
  logic [N*NQ-1:0]   req_q = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [PW-1:0]     res_prod;
  logic [TW-1:0]     res_tag;
  logic              busy;

  mult_share_sched #(.N(N), .M(M), .NQ(NQ), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_d(req_d), .req_q(req_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_prod(res_prod), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int prod; int e0; } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            model_ptr = 0;
  int            results_seen = 0;
  int            lane_d_val[N];
  int            lane_q_val[N];
  logic          prev_valid = 1'b0;
  logic          expect_idle = 1'b0;
  logic [PW-1:0] held_prod;
  logic [TW-1:0] held_tag;
  logic [N-1:0]  g_mon;
  logic [N-1:0]  g_drv;

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int model_winner(logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  function automatic int lane_of(logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: predicts grants, records expected products, checks results.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        check_output("idle_after_handshake", int'(busy), 0);
        expect_idle = 1'b0;
      end
      g_mon = req_valid & req_ready;
      if (busy) check_output("ready_low_when_busy", int'(req_ready), 0);
      if (!busy && req_valid != '0) check_output("grant_present", int'(g_mon != '0), 1);
      if (g_mon != '0) begin
        int w;
        exp_t e;
        w = model_winner(req_valid);
        check_output("grant_onehot", int'($onehot(g_mon)), 1);
        check_output("grant_winner", lane_of(g_mon), w);
        if (w >= 0) begin
          e.tag  = w;
          e.prod = lane_d_val[w] * lane_q_val[w];
          e.e0   = cyc + 1;
          sb.push_back(e);
          model_ptr = (w + 1) % N;
        end
      end
      if (res_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            check_output("unexpected_result", 0, 1);
          end else begin
            cur = sb.pop_front();
            check_output("res_prod", int'(res_prod), cur.prod);
            check_output("res_tag", int'(res_tag), cur.tag);
            check_output("latency", cyc - cur.e0, NQ);
            results_seen++;
          end
          held_prod = res_prod;
          held_tag  = res_tag;
        end else begin
          check_output("prod_stable", int'(res_prod), int'(held_prod));
          check_output("tag_stable", int'(res_tag), int'(held_tag));
          check_output("busy_in_done", int'(busy), 1);
        end
        if (res_ready) expect_idle = 1'b1;
      end
      prev_valid = res_valid && !res_ready;
    end
  end

  // Requester side: a granted lane drops its valid just after the accept edge.
  always @(negedge clk) begin
    g_drv = req_valid & req_ready;
    if (g_drv != '0 && rst_n) begin
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g_drv;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(int lane, int d, int q);
    lane_d_val[lane] = d;
    lane_q_val[lane] = q;
    req_d[lane*M +: M]   = M'(d);
    req_q[lane*NQ +: NQ] = NQ'(q);
    req_valid[lane] = 1'b1;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0 || res_valid) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check_output({name, "_timeout"}, n, 0);
  endtask

  task automatic wait_busy(string name);
    int n;
    n = 0;
    while (!busy && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_output({name, "_timeout"}, n, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    int lane;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check_output("rst_req_ready", int'(req_ready), 0);
    check_output("rst_res_valid", int'(res_valid), 0);
    check_output("rst_res_prod", int'(res_prod), 0);
    check_output("rst_res_tag", int'(res_tag), 0);
    check_output("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();

    // All four at once, then only 1 and 3.
    for (int i = 0; i < N; i++) apply_stimulus(i, 10 + i, 3 + 2 * i);
    wait_drain("all_four");
    apply_stimulus(1, 21, 5);
    apply_stimulus(3, 33, 7);
    wait_drain("pair_1_3");

    apply_stimulus(2, 13, 11);
    wait_drain("single_13x11");

    apply_stimulus(0, 255, 255); wait_drain("ext_255x255");
    apply_stimulus(0, 0, 200);   wait_drain("ext_0x200");
    apply_stimulus(0, 200, 0);   wait_drain("ext_200x0");
    apply_stimulus(0, 1, 255);   wait_drain("ext_1x255");

    // Back-pressure with another request pending during DONE.
    res_ready = 1'b0;
    apply_stimulus(2, 77, 91);
    n = 0;
    while (!res_valid && n < 100) begin step(); n++; end
    check_output("bp_reached_done", int'(res_valid), 1);
    apply_stimulus(0, 5, 6);
    repeat (20) step();
    res_ready = 1'b1;
    wait_drain("backpressure");

    // Reset in the 4th CALC cycle of an op on lane 1 (leaves ptr at 2).
    apply_stimulus(1, 99, 98);
    wait_busy("reset_accept");
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_output("midrst_res_valid", int'(res_valid), 0);
    check_output("midrst_res_prod", int'(res_prod), 0);
    check_output("midrst_res_tag", int'(res_tag), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_req_ready", int'(req_ready), 0);
    sb.delete();
    model_ptr = 0;
    step();
    rst_n = 1'b1;
    step();
    apply_stimulus(3, 4, 5);
    apply_stimulus(1, 7, 9);
    wait_drain("after_reset");

    // Withdrawal of lane 1 while lane 0 is being served.
    seen = results_seen;
    apply_stimulus(0, 12, 12);
    wait_busy("withdraw_accept");
    apply_stimulus(1, 50, 50);
    repeat (3) step();
    req_valid[1] = 1'b0;
    wait_drain("withdraw");
    repeat (20) step();
    check_output("withdraw_result_count", results_seen - seen, 1);

    // Randomized traffic with random back-pressure.
    for (int it = 0; it < 60; it++) begin
      lane = int'($urandom_range(N - 1, 0));
      if (!req_valid[lane])
        apply_stimulus(lane, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
      res_ready = 1'($urandom_range(1, 0));
      repeat ($urandom_range(4, 1)) step();
    end
    res_ready = 1'b1;
    wait_drain("random");

    check_output("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Shared-resource scheduler for the shift-add multiplier. N requesters each present an operand pair; the block picks one by round-robin and runs the sequential add/shift sequence for it on a single shared accumulator/shift-register datapath. It returns the product tagged with the requester index over a valid/ready result port. It sits between client blocks needing occasional products and the one multiply resource.

## Interface
- N, 4, number of requesters (2..8)
- M, 8, multiplicand (D) width
- NQ, 8, multiplier (Q) width; also the number of add/shift iterations
- TW, 2, tag width; must equal ceil(log2(N))

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N  bit i: requester i has an operand pair pending
- req_ready  out  N  bit i: requester i's pair is accepted this cycle; one-hot or zero
- req_d  in  N*M  lane i at [i*M +: M], multiplicand
- req_q  in  N*NQ  lane i at [i*NQ +: NQ], multiplier
- res_valid  out  1  product available
- res_ready  in  1  consumer takes product
- res_prod  out  M+NQ  unsigned product D*Q
- res_tag  out  TW  index of requester that owns res_prod
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - If any req_valid is high, pick the first set bit at or after pointer ptr, wrapping modulo N.
  - req_ready for the winner is combinational in IDLE; transfer happens on valid&ready.
  - On transfer: capture D, load Q into the low shift register, clear the accumulator (M+1 bits, including carry), store tag, set cnt=NQ, set ptr=(winner+1) mod N, go to CALC.
  - If no request is pending, stay in IDLE; ptr is unchanged.
- **CALC**, once per cycle:
  - If the low shift register LSB is 1, sum={1'b0,acc[M-1:0]}+D, otherwise sum={1'b0,acc[M-1:0]}.
  - Shift {sum, qreg} right by 1. The carry becomes the MSB.
  - Decrement cnt. When cnt reaches 0 after this step, go to DONE.
- **DONE**
  - res_valid=1; res_prod={acc[M-1:0], qreg}; res_tag is held.
  - If res_ready, go to IDLE. Otherwise hold all outputs stable.
- req_ready is 0 in CALC and DONE. A requester may drop req_valid before it is granted; a dropped request is never granted.
- Arithmetic is unsigned. The product is exact for all inputs and never truncated.
- Reset is asynchronous and takes effect mid-operation. State=IDLE, ptr=0, cnt=0, acc=0, qreg=0, tag=0. The in-flight operation is discarded and no result is produced.
- Reset values of outputs: req_ready=0 (until a valid request appears after reset), res_valid=0, res_prod=0, res_tag=0, busy=0.

## Timing
- Accept edge E0, with valid&ready in IDLE. CALC occupies the NQ cycles after E0.
- res_valid rises immediately after edge E0+NQ, so latency is NQ cycles from the accept edge.
- The handshake edge with res_ready in DONE returns the block to IDLE. The next accept happens at the earliest one cycle later.
- Minimum period per operation with res_ready tied high: NQ+2 cycles.
- When requests arrive at the same time, exactly one grant is issued per IDLE visit. Losers keep req_valid high and wait.
- With all N requesters continuously valid, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 other operations.
- Output registers: res_prod and res_tag change only on the CALC→DONE edge and on reset.

## Test plan
- Single op, requester 2: D=13, Q=11 → req_ready[2] pulses once; res_valid 8 cycles after accept; res_prod=143, res_tag=2.
- Extremes, requester 0: 255×255 → 65025 (carry path); 0×200 → 0; 200×0 → 0; 1×255 → 255.
- All four requesters valid from reset with distinct operands → grant order 0,1,2,3. Then re-assert only 1 and 3 → order 1,3. Each result is tagged correctly.
- Back-pressure: hold res_ready low 20 cycles in DONE → res_valid, res_prod and res_tag stable; busy=1; all req_ready=0. Release → IDLE next cycle.
- Reset asserted at the 4th CALC cycle → all outputs 0 immediately, with no clock edge needed. After release, a new request for 7×9 yields 63 and ptr restarts at 0.
- Withdrawal: requester 1 raises req_valid, then drops it while the block is busy on requester 0 → requester 1 is never granted and no extra result appears.
